// File: rtl/lfsr_gen.sv
// Galois LFSR stream generator; optional period-wrap flag via LFSR_PERIOD_CHECK_EN.
// Latency: the first word is valid one cycle after the request is accepted, then one word per handshake.
// Backpressure: with out_rdy low, out_msg and the state hold; the request side stalls until the run completes.
module lfsr_gen #(
  parameter int                nbits = 8,
  parameter logic [nbits-1:0]  TAPS  = 8'hB8,
  parameter int                cbits = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [nbits-1:0] req_seed,
  input  logic [cbits-1:0] req_cnt,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_msg,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  localparam logic [cbits-1:0] CNT_ONE  = {{(cbits-1){1'b0}}, 1'b1};
  localparam logic [nbits-1:0] SEED_ONE = {{(nbits-1){1'b0}}, 1'b1};

  st_t              st, st_nxt;
  logic [nbits-1:0] state_q;
  logic [nbits-1:0] nxt;
  logic [nbits-1:0] seed_eff;
  logic [nbits-1:0] reg_d;
  logic             reg_en;
  logic [cbits-1:0] remaining;
  logic             acc;
  logic             hs;

  assign nxt      = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  // An all-zero seed would lock the LFSR at zero forever.
  assign seed_eff = (req_seed == '0) ? SEED_ONE : req_seed;
  assign acc      = req_val && req_rdy;
  assign hs       = out_val && out_rdy;

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // Outputs are gated by rst so a run aborts at once and reset values show during reset.
  always_comb begin
    st_nxt  = st;
    req_rdy = 1'b0;
    out_val = 1'b0;
    done    = 1'b0;
    case (st)
      IDLE: begin
        req_rdy = !rst;
        if (req_val && !rst) st_nxt = (req_cnt == '0) ? DONE : RUN;
      end
      RUN: begin
        out_val = !rst;
        if (out_rdy && !rst && remaining == CNT_ONE) st_nxt = DONE;
      end
      DONE: begin
        done   = !rst;
        st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign out_msg = out_val ? state_q : '0;

  assign reg_en = acc || hs;
  assign reg_d  = acc ? seed_eff : nxt;

  always_ff @(posedge clk) begin
    if (rst)         state_q <= '0;
    else if (reg_en) state_q <= reg_d;
  end

  always_ff @(posedge clk) begin
    if (rst)                         remaining <= '0;
    else if (acc)                    remaining <= req_cnt;
    else if (hs && remaining != '0)  remaining <= remaining - CNT_ONE;
  end

`ifdef LFSR_PERIOD_CHECK_EN
  logic [nbits-1:0] seed_q;

  always_ff @(posedge clk) begin
    if (rst)      seed_q <= '0;
    else if (acc) seed_q <= seed_eff;
  end

  assign wrap = hs && (nxt == seed_q);
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: stimulus pushes expected words, a negedge monitor pops and compares.
// Latency: expects first word one cycle after request acceptance and done one cycle after the last handshake.
// Backpressure: stalls out_rdy mid-run and checks the held word.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic [7:0]  req_seed;
  logic [15:0] req_cnt;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  out_msg;
  logic        done;
  logic        wrap;

  lfsr_gen dut (
    .clk      (clk),
    .rst      (rst),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_seed (req_seed),
    .req_cnt  (req_cnt),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

`ifdef LFSR_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] msg;
    bit         last;
    bit         wrp;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         failures = 0;
  int         pops = 0;
  int         done_seen = 0;
  int         wrap_seen = 0;
  bit         done_pending = 1'b0;
  logic [7:0] last_msg = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (wrap === 1'b1) wrap_seen++;
    if (done_pending) begin
      check("done_after_last", {31'd0, done}, 32'd1);
      done_pending = 1'b0;
    end
    if (out_val === 1'b1 && out_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%0h expected none", out_msg);
      end else begin
        e = exp_q.pop_front();
        check("word", {24'd0, out_msg}, {24'd0, e.msg});
        check("wrap_flag", {31'd0, wrap}, {31'd0, e.wrp});
        if (e.last) done_pending = 1'b1;
        last_msg = out_msg;
        pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] m, input bit last);
    exp_t x;
    x.msg  = m;
    x.last = last;
    x.wrp  = 1'b0;
    exp_q.push_back(x);
  endtask

  task automatic send_req(input logic [7:0] seed, input logic [15:0] cnt);
    int n = 0;
    while (req_rdy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("req_rdy_before_req", {31'd0, req_rdy}, 32'd1);
    req_seed = seed;
    req_cnt  = cnt;
    req_val  = 1'b1;
    tick();
    req_val  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_pending) && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 32'd0);
    check("req_rdy_after_done", {31'd0, req_rdy}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int p0;
    int w0;
    int n;
    logic [7:0] s;
    exp_t x;

    rst = 1'b1; req_val = 1'b0; req_seed = 8'h00; req_cnt = 16'd0; out_rdy = 1'b1;

    // reset: all outputs low, req_rdy rises after deassert
    tick();
    check("rst_outputs", {27'd0, req_rdy, out_val, done, wrap, |out_msg}, 32'd0);
    tick();
    check("rst_outputs2", {27'd0, req_rdy, out_val, done, wrap, |out_msg}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("req_rdy_after_rst", {31'd0, req_rdy}, 32'd1);

    // basic run
    d0 = done_seen;
    push(8'h01, 0); push(8'hB8, 0); push(8'h5C, 1);
    send_req(8'h01, 16'd3);
    check("first_word_val", {31'd0, out_val}, 32'd1);
    check("first_word_msg", {24'd0, out_msg}, 32'h01);
    drain(50);
    check("basic_done_count", done_seen - d0, 32'd1);

    // zero seed becomes 1
    d0 = done_seen;
    push(8'h01, 0); push(8'hB8, 1);
    send_req(8'h00, 16'd2);
    drain(50);
    check("zseed_done_count", done_seen - d0, 32'd1);

    // zero count: done without words
    d0 = done_seen; p0 = pops;
    send_req(8'h42, 16'd0);
    check("zcnt_done", {31'd0, done}, 32'd1);
    check("zcnt_out_val", {31'd0, out_val}, 32'd0);
    tick();
    check("zcnt_done_gone", {31'd0, done}, 32'd0);
    check("zcnt_req_rdy", {31'd0, req_rdy}, 32'd1);
    check("zcnt_done_count", done_seen - d0, 32'd1);
    check("zcnt_no_words", pops - p0, 32'd0);

    // backpressure after first word, with a stray request that must be ignored
    d0 = done_seen;
    push(8'h01, 0); push(8'hB8, 0); push(8'h5C, 1);
    send_req(8'h01, 16'd3);
    tick();
    out_rdy = 1'b0; req_val = 1'b1; req_seed = 8'h77; req_cnt = 16'd5;
    for (int i = 0; i < 3; i++) begin
      check("bp_val", {31'd0, out_val}, 32'd1);
      check("bp_msg", {24'd0, out_msg}, 32'hB8);
      check("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
      tick();
    end
    out_rdy = 1'b1; req_val = 1'b0;
    drain(50);
    check("bp_done_count", done_seen - d0, 32'd1);

    // reset after the fourth word
    d0 = done_seen; p0 = pops;
    push(8'h01, 0); push(8'hB8, 0); push(8'h5C, 0); push(8'h2E, 0); push(8'h17, 0);
    push(8'hB3, 0); push(8'hE1, 0); push(8'hC8, 0); push(8'h64, 0); push(8'h32, 1);
    send_req(8'h01, 16'd10);
    n = 0;
    while (pops - p0 < 4 && n < 50) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    check("mid_rst_out_val", {31'd0, out_val}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_words", pops - p0, 32'd4);
    check("mid_rst_no_done", done_seen - d0, 32'd0);
    d0 = done_seen;
    push(8'h01, 0); push(8'hB8, 1);
    send_req(8'h01, 16'd2);
    check("restart_msg", {24'd0, out_msg}, 32'h01);
    drain(50);
    check("restart_done_count", done_seen - d0, 32'd1);

    // full period: 256 words, word 256 equals the seed again
    w0 = wrap_seen;
    s = 8'h01;
    for (int i = 1; i <= 256; i++) begin
      x.msg  = s;
      x.last = (i == 256);
      x.wrp  = PCHK && (step(s) == 8'h01);
      exp_q.push_back(x);
      s = step(s);
    end
    send_req(8'h01, 16'd256);
    drain(600);
    check("period_last_word", {24'd0, last_msg}, 32'h01);
    check("period_wrap_count", wrap_seen - w0, PCHK ? 32'd1 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Galois LFSR sequence generator: accepts a seed plus an output count over a val/rdy request interface, then streams that many successive LFSR states over a val/rdy output interface.
- Sits directly upstream of the state Register. Internally it drives the Register's en/d to hold the LFSR state and sequences steps with a small FSM.
- Feeds downstream consumers (scramblers, test-pattern sinks) one word per accepted handshake.

Parameters:
- nbits, 8, LFSR state width.
- TAPS, 8'hB8, Galois feedback mask, nbits wide. The default gives a maximal-length 8-bit sequence (period 255).
- cbits, 16, width of the output-count field.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_val  input  1  seed/count request valid.
- req_rdy  output  1  generator can accept a request.
- req_seed  input  nbits  initial LFSR state.
- req_cnt  input  cbits  number of words to emit.
- out_val  output  1  out_msg holds a valid LFSR word.
- out_rdy  input  1  consumer accepts out_msg.
- out_msg  output  nbits  current LFSR state.
- done  output  1  one-cycle pulse when the request completes.
- wrap  output  1  period-wrap pulse (see Optional Feature).

Behaviour:
- Reset: FSM enters IDLE. State register, remaining counter and captured seed clear to 0. Output values during reset: req_rdy=0, out_val=0, out_msg=0, done=0, wrap=0. req_rdy rises the cycle after rst deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_rdy=1, out_val=0.
  - Request handshake is req_val&&req_rdy. On it, capture the seed and remaining<=req_cnt.
  - req_seed==0 is replaced by 1 (lockup avoidance); the substituted value is also the captured seed.
  - req_cnt==0 -> DONE with no output words. Otherwise -> RUN.
- RUN:
  - req_rdy=0, out_val=1, out_msg=state.
  - First word is valid the cycle after request acceptance (1-cycle latency).
  - On out_val&&out_rdy: state<=next, where next=(state>>1)^(state[0]?TAPS:0); remaining<=remaining-1.
  - If remaining==1 at that handshake -> DONE.
  - With out_rdy=0: state and out_msg hold unchanged; out_val stays high. A word may not be dropped or repeated.
- DONE:
  - done=1 for exactly one cycle; out_val=0, req_rdy=0. -> IDLE next cycle.
  - The state register keeps the last advanced value; it is not visible because out_val=0.
- req_val is ignored outside IDLE; no queueing.
- Reset mid-RUN: the run aborts immediately, with no done pulse. Outputs return to reset values the next edge.
- Arithmetic: remaining is an unsigned cbits counter and never decrements below 0. All shifts are logical, nbits wide. No wrap of remaining is possible.
- The Register's en is asserted only on request capture and on output handshakes.

Optional Feature:
- Macro: LFSR_PERIOD_CHECK_EN.
- Defined: in RUN, on an output handshake where next==captured seed, wrap=1 for that same cycle (combinational with the handshake). The sequence continues normally.
- Undefined: wrap is tied to 0 and the seed compare logic is not built. The port is always present.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0 during reset; req_rdy=1 the cycle after deassert.
- Basic run: seed=0x01, cnt=3, out_rdy=1 -> out_msg sequence 0x01, 0xB8, 0x5C on consecutive cycles; done pulses 1 cycle after the 3rd handshake; then req_rdy=1.
- Zero seed and zero count: seed=0x00, cnt=2 -> outputs 0x01, 0xB8. Separately seed=0x42, cnt=0 -> no out_val, done the cycle after acceptance.
- Backpressure: seed=0x01, cnt=3, out_rdy low for 3 cycles after the first word -> out_msg holds 0xB8 with out_val=1 throughout; the sequence resumes correctly.
- Reset mid-run: seed=0x01, cnt=10, rst after the 4th word -> out_val=0 and no done pulse; a new request seed=0x01 restarts at 0x01.
- Period check (LFSR_PERIOD_CHECK_EN defined): seed=0x01, cnt=256 -> wrap pulses once, on handshake 255. Word 256 equals 0x01. Undefined: wrap stays 0.
